// File: rtl/weight_sram_loader.sv
// Weight SRAM write-side loader: packs a valid/ready byte stream into SRAM lines
// addressed {layer, line}, one pass per start, pulsing done with the final write.
module weight_sram_loader #(
  parameter int FV_SIZE              = 8,
  parameter int MULT_PER_PE          = 2,
  parameter int MAX_FV_NUM           = 16,
  parameter int MAX_NUM_WEIGHT_LAYER = 4,
  parameter int SRAM_BW              = 64,
  parameter int LAYER_W              = $clog2(MAX_NUM_WEIGHT_LAYER),
  parameter int LINE_W               = $clog2(MAX_FV_NUM / MULT_PER_PE),
  parameter int FVN_W                = $clog2(MAX_FV_NUM) + 1,
  parameter int ADDR_W               = LAYER_W + LINE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W-1:0] Num_Weight_layer,
  input  logic [FVN_W-1:0]   Num_FV,
  input  logic               in_valid,
  input  logic [FV_SIZE-1:0] in_data,
  output logic               in_ready,
  output logic               CEN,
  output logic               WEN,
  output logic [ADDR_W-1:0]  A,
  output logic [SRAM_BW-1:0] D,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for a start with a legal Num_FV
  // LOAD  | accepting bytes, issuing one write per completed line
  // DONE  | final write presented with the done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int LANE_W = (MULT_PER_PE > 1) ? $clog2(MULT_PER_PE) : 1;
  localparam int PACK_W = FV_SIZE * MULT_PER_PE;

  logic [1:0]         state_q, state_d;
  logic [LAYER_W-1:0] cfg_layer_q, cfg_layer_d;
  logic [FVN_W-1:0]   cfg_fv_q, cfg_fv_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [FVN_W-1:0]   fv_cnt_q, fv_cnt_d;
  logic [PACK_W-1:0]  pack_q, pack_d;
  logic               cen_q, cen_d;
  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  a_q, a_d;
  logic [SRAM_BW-1:0] d_q, d_d;

  logic [PACK_W-1:0]  pack_w;
  logic [FVN_W-1:0]   fv_next;
  logic               line_done;
  logic               layer_done;
  logic               cfg_ok;

  assign cfg_ok     = (Num_FV != '0) && (Num_FV <= FVN_W'(MAX_FV_NUM));
  assign fv_next    = fv_cnt_q + FVN_W'(1);
  assign layer_done = (fv_next == cfg_fv_q);
  assign line_done  = (lane_q == LANE_W'(MULT_PER_PE - 1)) || layer_done;

  always_comb begin
    pack_w = pack_q;
    for (int l = 0; l < MULT_PER_PE; l++) begin
      if (lane_q == LANE_W'(l)) pack_w[l*FV_SIZE +: FV_SIZE] = in_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_layer_d = cfg_layer_q;
    cfg_fv_d    = cfg_fv_q;
    layer_d     = layer_q;
    line_d      = line_q;
    lane_d      = lane_q;
    fv_cnt_d    = fv_cnt_q;
    pack_d      = pack_q;
    cen_d       = 1'b1;
    wen_d       = 1'b1;
    a_d         = '0;
    d_d         = '0;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          state_d     = S_LOAD;
          cfg_layer_d = Num_Weight_layer;
          cfg_fv_d    = Num_FV;
          layer_d     = '0;
          line_d      = '0;
          lane_d      = '0;
          fv_cnt_d    = '0;
          pack_d      = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          pack_d   = pack_w;
          fv_cnt_d = fv_next;
          lane_d   = lane_q + LANE_W'(1);
          // Cleared lanes above the last byte give the zero padding for free.
          if (line_done) begin
            cen_d              = 1'b0;
            wen_d              = 1'b0;
            a_d                = {layer_q, line_q};
            d_d[PACK_W-1:0]    = pack_w;
            pack_d             = '0;
            lane_d             = '0;
            line_d             = line_q + LINE_W'(1);
          end
          if (layer_done) begin
            fv_cnt_d = '0;
            line_d   = '0;
            layer_d  = layer_q + LAYER_W'(1);
            if (layer_q == cfg_layer_q) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cfg_layer_q <= '0;
      cfg_fv_q    <= '0;
      layer_q     <= '0;
      line_q      <= '0;
      lane_q      <= '0;
      fv_cnt_q    <= '0;
      pack_q      <= '0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      cfg_layer_q <= cfg_layer_d;
      cfg_fv_q    <= cfg_fv_d;
      layer_q     <= layer_d;
      line_q      <= line_d;
      lane_q      <= lane_d;
      fv_cnt_q    <= fv_cnt_d;
      pack_q      <= pack_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign CEN      = cen_q;
  assign WEN      = wen_q;
  assign A        = a_q;
  assign D        = d_q;

endmodule

// File: tb/tb_weight_sram_loader.sv
// Bench for weight_sram_loader: directed scenarios plus randomized loads checked
// against an arithmetic model of the expected SRAM write list.
module tb_weight_sram_loader;

  localparam int MPE   = 2;
  localparam int LINES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  Num_Weight_layer = '0;
  logic [4:0]  Num_FV = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        CEN;
  logic        WEN;
  logic [4:0]  A;
  logic [63:0] D;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  stim[$];
  int          w_a[$];
  logic [63:0] w_d[$];
  int          w_cyc[$];
  logic        w_wen[$];
  int          hs_cyc[$];
  int          done_cyc[$];
  logic        done_rdy;
  int          idle_bad;
  int          exp_a[$];
  logic [63:0] exp_d[$];
  int          exp_g[$];
  int          start_cyc;
  logic        t1_busy, t1_rdy, busy_after;

  weight_sram_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .Num_Weight_layer(Num_Weight_layer), .Num_FV(Num_FV),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (CEN === 1'b0) begin
      w_a.push_back(int'(A));
      w_d.push_back(D);
      w_cyc.push_back(cyc);
      w_wen.push_back(WEN);
    end else if (WEN !== 1'b1 || A !== '0 || D !== '0) begin
      idle_bad++;
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) hs_cyc.push_back(cyc);
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_rdy = in_ready;
    end
  end

  task automatic clear_mon();
    w_a.delete(); w_d.delete(); w_cyc.delete(); w_wen.delete();
    hs_cyc.delete(); done_cyc.delete();
    idle_bad = 0;
    done_rdy = 1'bx;
  endtask

  // Expected writes: layer L, line k holds weights k*MPE.. of that layer, lane 0 low.
  function automatic void build_model(input int nl, input int nfv);
    int lines;
    lines = (nfv + MPE - 1) / MPE;
    exp_a.delete(); exp_d.delete(); exp_g.delete();
    for (int L = 0; L <= nl; L++) begin
      for (int k = 0; k < lines; k++) begin
        logic [63:0] d;
        int last;
        d = '0;
        last = 0;
        for (int j = 0; j < MPE; j++) begin
          int idx;
          idx = k * MPE + j;
          if (idx < nfv) begin
            d = d | (64'(stim[L * nfv + idx]) << (8 * j));
            last = L * nfv + idx;
          end
        end
        exp_a.push_back(L * LINES + k);
        exp_d.push_back(d);
        exp_g.push_back(last);
      end
    end
  endfunction

  // gap < 0 selects a random 0..2 idle cycles after each byte.
  task automatic drive_load(input int nl, input int nfv, input int gap, input int mid_start);
    int n;
    int g;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    Num_Weight_layer = 2'(nl);
    Num_FV = 5'(nfv);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    t1_busy = busy;
    t1_rdy = in_ready;
    for (int i = 0; i < stim.size(); i++) begin
      in_valid = 1'b1;
      in_data = stim[i];
      if (i == mid_start) begin
        start = 1'b1;
        Num_FV = 5'd2;
        Num_Weight_layer = 2'd0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      start = 1'b0;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin @(posedge clk); #1; end
    end
    n = 0;
    while (done_cyc.size() == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cyc.size() == 0) begin
      failures++;
      $display("FAIL done_timeout got no done within 40 cycles, required one");
    end
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, CEN, WEN, A, D, busy, done} !== {1'b0, 1'b1, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got rdy=%b CEN=%b WEN=%b A=%0d D=%h busy=%b done=%b required 0 1 1 0 0 0 0",
               in_ready, CEN, WEN, A, D, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_layer();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive_load(0, 4, 0, -1);
    build_model(0, 4);
    checks++;
    if (w_a.size() !== 2 || (w_a.size() == 2 && (w_d[0] !== 64'h0201 || w_d[1] !== 64'h0403))) begin
      failures++;
      $display("FAIL single_literal got %0d writes, required A0=0201 A1=0403", w_a.size());
    end
    for (int i = 0; i < w_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (w_a[i] !== exp_a[i] || w_d[i] !== exp_d[i] || w_wen[i] !== 1'b0) begin
        failures++;
        $display("FAIL single_write%0d got A=%0d D=%h WEN=%b required A=%0d D=%h WEN=0",
                 i, w_a[i], w_d[i], w_wen[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (t1_busy !== 1'b1 || t1_rdy !== 1'b1) begin
      failures++;
      $display("FAIL single_t1 got busy=%b rdy=%b required 1 1", t1_busy, t1_rdy);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - start_cyc != 5) begin
      failures++;
      $display("FAIL single_latency got %0d cycles start to done, required 5",
               (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1);
    end
    checks++;
    if (w_cyc.size() > 0 && done_cyc.size() > 0 && (done_cyc[0] !== w_cyc[w_cyc.size()-1] || done_rdy !== 1'b0 || busy_after !== 1'b0)) begin
      failures++;
      $display("FAIL single_done got done_cyc=%0d last_write=%0d rdy=%b busy_after=%b required equal, 0, 0",
               done_cyc[0], w_cyc[w_cyc.size()-1], done_rdy, busy_after);
    end
  endtask

  task automatic test_multi_layer();
    stim = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    drive_load(1, 3, 0, -1);
    build_model(1, 3);
    checks++;
    if (w_a.size() !== exp_a.size()) begin
      failures++;
      $display("FAIL multi_nwrites got %0d required %0d", w_a.size(), exp_a.size());
    end
    for (int i = 0; i < w_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (w_a[i] !== exp_a[i] || w_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL multi_write%0d got A=%0d D=%h required A=%0d D=%h", i, w_a[i], w_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (w_a.size() == 4 && (w_a[2] !== 8 || w_d[3] !== 64'h0023)) begin
      failures++;
      $display("FAIL multi_literal got A2=%0d D3=%h required 8 0023", w_a[2], w_d[3]);
    end
  endtask

  task automatic test_gaps();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive_load(0, 4, 3, -1);
    build_model(0, 4);
    checks++;
    if (w_a.size() !== exp_a.size() || idle_bad != 0) begin
      failures++;
      $display("FAIL gaps_nwrites got %0d writes idle_bad=%0d required %0d and 0", w_a.size(), idle_bad, exp_a.size());
    end
    for (int i = 0; i < w_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (w_a[i] !== exp_a[i] || w_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL gaps_write%0d got A=%0d D=%h required A=%0d D=%h", i, w_a[i], w_d[i], exp_a[i], exp_d[i]);
      end
      checks++;
      if (exp_g[i] >= hs_cyc.size() || w_cyc[i] !== hs_cyc[exp_g[i]] + 1) begin
        failures++;
        $display("FAIL gaps_timing%0d got write cycle %0d required one after handshake", i, w_cyc[i]);
      end
    end
  endtask

  task automatic test_bad_cfg();
    clear_mon();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      Num_FV = (k == 0) ? 5'd0 : 5'd17;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || CEN !== 1'b1) begin
        failures++;
        $display("FAIL bad_cfg%0d got busy=%b rdy=%b CEN=%b required 0 0 1", k, busy, in_ready, CEN);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w_a.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_cfg_writes got %0d writes busy=%b required 0 0", w_a.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; Num_Weight_layer = 2'd0; Num_FV = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h50 + i);
      @(posedge clk); #1;
    end
    in_data = 8'h53;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, CEN, WEN, A, D, busy, done} !== {1'b0, 1'b1, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_values got rdy=%b CEN=%b WEN=%b A=%0d D=%h busy=%b done=%b required 0 1 1 0 0 0 0",
               in_ready, CEN, WEN, A, D, busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w_a.size() != 1 || (w_a.size() == 1 && (w_a[0] !== 0 || w_d[0] !== 64'h5150))) begin
      failures++;
      $display("FAIL reset_mid_partial got %0d writes required exactly A=0 D=5150", w_a.size());
    end
    stim = '{8'hAA, 8'hBB};
    drive_load(0, 2, 0, -1);
    checks++;
    if (w_a.size() != 1 || (w_a.size() == 1 && (w_a[0] !== 0 || w_d[0] !== 64'hBBAA))) begin
      failures++;
      $display("FAIL reset_restart got %0d writes A=%0d required one write A=0 D=bbaa",
               w_a.size(), (w_a.size() > 0) ? w_a[0] : -1);
    end
  endtask

  task automatic test_full_mid_start();
    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back(8'($urandom));
    drive_load(3, 16, 0, 10);
    build_model(3, 16);
    checks++;
    if (w_a.size() !== 32) begin
      failures++;
      $display("FAIL full_nwrites got %0d required 32", w_a.size());
    end
    for (int i = 0; i < w_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (w_a[i] !== i || w_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL full_write%0d got A=%0d D=%h required A=%0d D=%h", i, w_a[i], w_d[i], i, exp_d[i]);
      end
    end
    checks++;
    if (w_cyc.size() == 0 || done_cyc.size() != 1 || done_cyc[0] !== w_cyc[w_cyc.size()-1]) begin
      failures++;
      $display("FAIL full_done got %0d done pulses, required one coinciding with A=31", done_cyc.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nl, nfv;
      nl = int'($urandom_range(0, 3));
      nfv = int'($urandom_range(1, 16));
      stim.delete();
      for (int i = 0; i < (nl + 1) * nfv; i++) stim.push_back(8'($urandom));
      drive_load(nl, nfv, -1, -1);
      build_model(nl, nfv);
      checks++;
      if (w_a.size() !== exp_a.size() || idle_bad != 0) begin
        failures++;
        $display("FAIL rand%0d_nwrites nl=%0d nfv=%0d got %0d idle_bad=%0d required %0d 0",
                 it, nl, nfv, w_a.size(), idle_bad, exp_a.size());
      end
      for (int i = 0; i < w_a.size() && i < exp_a.size(); i++) begin
        checks++;
        if (w_a[i] !== exp_a[i] || w_d[i] !== exp_d[i] || exp_g[i] >= hs_cyc.size()
            || w_cyc[i] !== hs_cyc[exp_g[i]] + 1) begin
          failures++;
          $display("FAIL rand%0d_write%0d got A=%0d D=%h cyc=%0d required A=%0d D=%h one cycle after handshake",
                   it, i, w_a[i], w_d[i], w_cyc[i], exp_a[i], exp_d[i]);
        end
      end
      checks++;
      if (w_cyc.size() == 0 || done_cyc.size() != 1 || done_cyc[0] !== w_cyc[w_cyc.size()-1] || busy_after !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_done got %0d pulses busy_after=%b required one with last write, busy 0",
                 it, done_cyc.size(), busy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_multi_layer();
    test_gaps();
    test_bad_cfg();
    test_reset_mid();
    test_full_mid_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
